// File: rtl/flex_fifo_pkg.sv
// Shared constants and state type for the flex-bus FIFO slave.
// Register offsets are relative to base_addr; the status layout puts the flags in bits 15..12.
package flex_fifo_pkg;

    localparam logic [1:0] OFS_DATA = 2'd0;
    localparam logic [1:0] OFS_STAT = 2'd1;
    localparam logic [1:0] OFS_CTRL = 2'd2;

    localparam int STAT_OVF   = 15;
    localparam int STAT_UDF   = 14;
    localparam int STAT_FULL  = 13;
    localparam int STAT_EMPTY = 12;

    localparam int CTRL_CLR       = 0;
    localparam int CTRL_CLR_FLAGS = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_HOLD = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/flex_fifo_slave_fifo_sc.sv
// Single-clock show-ahead FIFO: rdata always presents the head word.
// Clear dominates push/pop. A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fifo_sc #(
    parameter int width = 16,
    parameter int depth = 16,
    localparam int AW = (depth > 1) ? $clog2(depth) : 1,
    localparam int CW = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(depth));
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & ~clear & (~full | do_pop);

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/flex_fifo_slave.sv
// Flex-bus slave exposing a hardware-fed FIFO through data, status and control registers.
// Reads and writes are acknowledged with a single-cycle dtack one cycle after the access edge.
module flex_fifo_slave
    import flex_fifo_pkg::*;
#(
    parameter int                    data_bus_width = 16,
    parameter int                    addr_width     = 16,
    parameter logic [addr_width-1:0] base_addr      = 16'h0200,
    parameter int                    fifo_depth     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [addr_width-1:0]     adr,
    input  logic [data_bus_width-1:0] data_w,
    input  logic                      ext_adr_val,
    input  logic                      ext_rd_act,
    input  logic                      ext_wr_act,
    input  logic                      push,
    input  logic [data_bus_width-1:0] push_data,
    output logic [data_bus_width-1:0] data_r,
    output logic                      data_r_act,
    output logic                      dtack,
    output logic                      not_empty
);

    localparam int CW = $clog2(fifo_depth + 1);

    state_t                    state_reg, state_next;
    logic [data_bus_width-1:0] data_r_reg, data_r_next;
    logic                      data_r_act_reg, data_r_act_next;
    logic                      dtack_reg, dtack_next;
    logic                      not_empty_reg;
    logic                      rd_act_d_reg, wr_act_d_reg;
    logic                      ovf_reg, udf_reg;

    logic [addr_width-1:0]     ofs;
    logic [1:0]                reg_sel;
    logic                      hit, rd_start, wr_start;
    logic                      pop_req, clr_fifo, clr_flags, set_udf, set_ovf;
    logic [data_bus_width-1:0] fifo_rdata;
    logic [data_bus_width-1:0] status_word;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_full, fifo_empty;
    logic                      unused_wbits;

    assign ofs      = adr - base_addr;
    assign reg_sel  = ofs[1:0];
    assign hit      = ext_adr_val && (ofs < addr_width'(3));
    assign rd_start = hit & ext_rd_act & ~rd_act_d_reg;
    assign wr_start = hit & ext_wr_act & ~wr_act_d_reg;
    assign set_ovf  = push & fifo_full & ~pop_req & ~clr_fifo;
    assign unused_wbits = ^data_w[data_bus_width-1:2];

    fifo_sc #(
        .width (data_bus_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clock),
        .srst  (reset),
        .push  (push),
        .pop   (pop_req),
        .clear (clr_fifo),
        .wdata (push_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word             = '0;
        status_word[CW-1:0]     = fifo_count;
        status_word[STAT_OVF]   = ovf_reg;
        status_word[STAT_UDF]   = udf_reg;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
    end

    always_comb begin
        state_next      = state_reg;
        data_r_next     = data_r_reg;
        data_r_act_next = data_r_act_reg;
        dtack_next      = 1'b0;
        pop_req         = 1'b0;
        clr_fifo        = 1'b0;
        clr_flags       = 1'b0;
        set_udf         = 1'b0;
        case (state_reg)
            IDLE: begin
                // Read wins if both edges arrive together.
                if (rd_start) begin
                    dtack_next      = 1'b1;
                    data_r_act_next = 1'b1;
                    state_next      = RD_HOLD;
                    case (reg_sel)
                        OFS_DATA: begin
                            if (fifo_empty) begin
                                data_r_next = '0;
                                set_udf     = 1'b1;
                            end else begin
                                data_r_next = fifo_rdata;
                                pop_req     = 1'b1;
                            end
                        end
                        OFS_STAT: data_r_next = status_word;
                        default:  data_r_next = '0;
                    endcase
                end else if (wr_start) begin
                    dtack_next = 1'b1;
                    state_next = WR_WAIT;
                    if (reg_sel == OFS_CTRL) begin
                        clr_fifo  = data_w[CTRL_CLR];
                        clr_flags = data_w[CTRL_CLR_FLAGS];
                    end
                end
            end
            RD_HOLD: begin
                if (!ext_rd_act) begin
                    data_r_next     = '0;
                    data_r_act_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            WR_WAIT: begin
                if (!ext_wr_act)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge detectors keep following the bus during reset, so a cycle still held
    // across reset is not mistaken for a fresh access afterwards.
    always_ff @(posedge clock) begin
        rd_act_d_reg <= ext_rd_act;
        wr_act_d_reg <= ext_wr_act;
        if (reset) begin
            state_reg      <= IDLE;
            data_r_reg     <= '0;
            data_r_act_reg <= 1'b0;
            dtack_reg      <= 1'b0;
            not_empty_reg  <= 1'b0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            data_r_reg     <= data_r_next;
            data_r_act_reg <= data_r_act_next;
            dtack_reg      <= dtack_next;
            not_empty_reg  <= ~fifo_empty;
            if (clr_flags) begin
                ovf_reg <= 1'b0;
                udf_reg <= 1'b0;
            end
            if (set_ovf)
                ovf_reg <= 1'b1;
            if (set_udf)
                udf_reg <= 1'b1;
        end
    end

    assign data_r     = data_r_reg;
    assign data_r_act = data_r_act_reg;
    assign dtack      = dtack_reg;
    assign not_empty  = not_empty_reg;

endmodule
